// File: rtl/pcap_frame_decoder.sv
// pcap_frame_decoder: parses Ethernet II / IPv4 / TCP / UDP headers from a
// single-byte replay bus, forwards the L4 payload with a one-beat hold so
// pl_last can ride on the final byte, and reports per-frame status.
module pcap_frame_decoder #(
  parameter int unsigned MAX_FRAME = 2048
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        available,
  input  logic        datavalid,
  input  logic [7:0]  data,
  output logic [47:0] eth_dst,
  output logic [47:0] eth_src,
  output logic [15:0] ethertype,
  output logic [31:0] ip_src,
  output logic [31:0] ip_dst,
  output logic [7:0]  ip_proto,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic        is_ipv4,
  output logic        is_tcp,
  output logic        is_udp,
  output logic        hdr_valid,
  output logic        pl_valid,
  output logic [7:0]  pl_data,
  output logic        pl_last,
  output logic        frame_done,
  output logic        frame_error,
  output logic [15:0] frame_len,
  output logic [7:0]  frame_count
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ETH, ST_IP, ST_L4, ST_PAYLOAD, ST_SKIP, ST_END
  } state_t;

  state_t      state_q, state_d, cur;
  logic [5:0]  idx_q, idx_d, cur_idx;
  logic        prev_avail;
  logic        frame_open, active, take, close;
  logic        hdr_fire, skip_err;
  logic [3:0]  ihl_q;
  logic [5:0]  l4_last_q;
  logic [5:0]  ip_last;
  logic [15:0] byte_cnt;
  logic        hdr_seen, err_q, ovf_q;
  logic        hold_valid;
  logic [7:0]  hold_data;

  // Index of the last IPv4 header byte, options included.
  assign ip_last = {ihl_q, 2'b00} - 6'd1;

  // Next-state decode; the opening cycle is treated as ETH byte 0 so a byte
  // arriving together with the rising edge of available is not lost.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    frame_open = (state_q == ST_IDLE || state_q == ST_END) && available && !prev_avail;
    active     = state_q inside {ST_ETH, ST_IP, ST_L4, ST_PAYLOAD, ST_SKIP};
    cur        = frame_open ? ST_ETH : state_q;
    cur_idx    = frame_open ? 6'd0 : idx_q;
    take       = datavalid && (frame_open || active);
    close      = active && !available;
    hdr_fire   = 1'b0;
    skip_err   = 1'b0;
    state_d    = cur;
    idx_d      = (take && (cur == ST_ETH || cur == ST_IP || cur == ST_L4)) ? cur_idx + 6'd1 : cur_idx;
    case (cur)
      ST_ETH: begin
        if (take && cur_idx == 6'd13) begin
          idx_d = 6'd0;
          if ({ethertype[7:0], data} == 16'h0800) begin
            state_d = ST_IP;
          end else begin
            hdr_fire = 1'b1;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_IP: begin
        if (take) begin
          if (cur_idx == 6'd0) begin
            if (data[7:4] != 4'd4 || data[3:0] < 4'd5) begin
              skip_err = 1'b1;
              state_d  = ST_SKIP;
              idx_d    = 6'd0;
            end
          end else if (cur_idx == ip_last) begin
            idx_d = 6'd0;
            if (is_tcp || is_udp) begin
              state_d = ST_L4;
            end else begin
              hdr_fire = 1'b1;
              state_d  = ST_PAYLOAD;
            end
          end
        end
      end
      ST_L4: begin
        if (take) begin
          if (is_tcp && cur_idx == 6'd12 && data[7:4] < 4'd5) begin
            skip_err = 1'b1;
            state_d  = ST_SKIP;
            idx_d    = 6'd0;
          end else if ((is_udp && cur_idx == 6'd7) ||
                       (is_tcp && cur_idx > 6'd12 && cur_idx == l4_last_q)) begin
            hdr_fire = 1'b1;
            state_d  = ST_PAYLOAD;
            idx_d    = 6'd0;
          end
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: ;
    endcase
    if (close) begin
      state_d = ST_END;
      idx_d   = 6'd0;
    end
  end

  // State register and available edge detector.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= 6'd0;
      // NOTE: prev_avail resets high so a frame already in flight at reset release is never seen as a rising edge.
      prev_avail <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      idx_q      <= idx_d;
      prev_avail <= available;
    end
  end

  // Header field capture; fields shift in wire order as their bytes are accepted.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      eth_dst   <= '0;
      eth_src   <= '0;
      ethertype <= '0;
      ip_src    <= '0;
      ip_dst    <= '0;
      ip_proto  <= '0;
      src_port  <= '0;
      dst_port  <= '0;
      is_ipv4   <= 1'b0;
      is_tcp    <= 1'b0;
      is_udp    <= 1'b0;
      hdr_valid <= 1'b0;
      ihl_q     <= 4'd5;
      l4_last_q <= 6'd19;
    end else begin
      hdr_valid <= hdr_fire;
      if (frame_open) begin
        ip_src   <= '0;
        ip_dst   <= '0;
        ip_proto <= '0;
        src_port <= '0;
        dst_port <= '0;
        is_ipv4  <= 1'b0;
        is_tcp   <= 1'b0;
        is_udp   <= 1'b0;
      end
      if (take) begin
        case (cur)
          ST_ETH: begin
            if (cur_idx < 6'd6)       eth_dst   <= {eth_dst[39:0], data};
            else if (cur_idx < 6'd12) eth_src   <= {eth_src[39:0], data};
            else                      ethertype <= {ethertype[7:0], data};
          end
          ST_IP: begin
            if (cur_idx == 6'd0) begin
              ihl_q   <= data[3:0];
              is_ipv4 <= (data[7:4] == 4'd4) && (data[3:0] >= 4'd5);
            end
            if (cur_idx == 6'd9) begin
              ip_proto <= data;
              is_tcp   <= (data == 8'd6);
              is_udp   <= (data == 8'd17);
            end
            if (cur_idx >= 6'd12 && cur_idx < 6'd16) ip_src <= {ip_src[23:0], data};
            if (cur_idx >= 6'd16 && cur_idx < 6'd20) ip_dst <= {ip_dst[23:0], data};
          end
          ST_L4: begin
            if (cur_idx < 6'd2)      src_port <= {src_port[7:0], data};
            else if (cur_idx < 6'd4) dst_port <= {dst_port[7:0], data};
            if (cur_idx == 6'd12)    l4_last_q <= {data[7:4], 2'b00} - 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Payload stream: each byte is held until the next one (or frame close)
  // so the final byte can carry pl_last without an empty beat.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pl_valid   <= 1'b0;
      pl_data    <= '0;
      pl_last    <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      pl_valid <= 1'b0;
      pl_last  <= 1'b0;
      if (state_q == ST_END) begin
        if (hold_valid) begin
          pl_valid <= 1'b1;
          pl_data  <= hold_data;
          pl_last  <= 1'b1;
        end
        hold_valid <= 1'b0;
      end else if (cur == ST_PAYLOAD && take) begin
        if (hold_valid) begin
          pl_valid <= 1'b1;
          pl_data  <= hold_data;
        end
        hold_data  <= data;
        hold_valid <= 1'b1;
      end
    end
  end

  // Frame accounting: saturating byte count, error flags and end-of-frame status.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      byte_cnt    <= '0;
      hdr_seen    <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_len   <= '0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state_q == ST_END) begin
        frame_done  <= 1'b1;
        frame_len   <= byte_cnt;
        frame_error <= err_q || !hdr_seen || ovf_q;
        frame_count <= frame_count + 8'd1;
      end
      if (frame_open) begin
        byte_cnt <= datavalid ? 16'd1 : 16'd0;
        hdr_seen <= 1'b0;
        err_q    <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        if (take) begin
          if (byte_cnt == 16'(MAX_FRAME)) ovf_q <= 1'b1;
          else                           byte_cnt <= byte_cnt + 16'd1;
        end
        if (hdr_fire) hdr_seen <= 1'b1;
        if (skip_err) err_q    <= 1'b1;
      end
    end
  end

endmodule
